// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and constants for the sound event scheduler.
// SOUND_GAP_EN adds the S_GAP state (one silent tick after non-death sounds).
package sound_pkg;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned KCNT_W = 3;

    localparam logic [KEY_W-1:0] KEY_SHOT   = 4'd1;
    localparam logic [KEY_W-1:0] KEY_DEATH  = 4'd2;
    localparam logic [KEY_W-1:0] KEY_KILL   = 4'd3;
    localparam logic [KEY_W-1:0] KEY_SILENT = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_END  = 2'd2
`ifdef SOUND_GAP_EN
        , S_GAP = 2'd3
`endif
    } sched_state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_SHOT  = 2'd1,
        EV_KILL  = 2'd2,
        EV_DEATH = 2'd3
    } event_t;

    // One cycle's worth of game-logic event requests.
    typedef struct packed {
        logic              shot;
        logic [KCNT_W-1:0] kills;
        logic              death;
    } ev_req_t;

    function automatic logic [KEY_W-1:0] event_key(input event_t ev);
        logic [KEY_W-1:0] k;
        case (ev)
            EV_SHOT:  k = KEY_SHOT;
            EV_KILL:  k = KEY_KILL;
            EV_DEATH: k = KEY_DEATH;
            default:  k = KEY_SILENT;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sound_event_scheduler_if.sv
// Event inputs from game logic and tone-select outputs to the tone generator.
interface sound_event_scheduler_if;

    logic                         slowClk;
    logic                         shotFired;
    logic [sound_pkg::KCNT_W-1:0] enemyDead;
    logic                         playerDead;
    logic [sound_pkg::KEY_W-1:0]  sound_key;
    logic                         sound_active;
    logic                         game_over;

    modport master (
        output slowClk, shotFired, enemyDead, playerDead,
        input  sound_key, sound_active, game_over
    );

    modport slave (
        input  slowClk, shotFired, enemyDead, playerDead,
        output sound_key, sound_active, game_over
    );

endinterface

// File: rtl/sound_event_scheduler_pending_queue.sv
// Latches pending sound requests and presents the highest-priority one.
// pop consumes whichever event is currently on top_ev_c.
module sound_pending_queue
    import sound_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  ev_req_t req,
    input  logic    freeze,
    input  logic    pop,
    output event_t  top_ev_c
);

    logic              shot_pend_q, shot_pend_d;
    logic              death_pend_q, death_pend_d;
    logic [KCNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic              pop_shot, pop_kill, pop_death;
    logic [KCNT_W:0]   kill_sum;

    // Priority: death, then kill, then shot.
    always_comb begin
        top_ev_c = EV_NONE;
        if (death_pend_q)                  top_ev_c = EV_DEATH;
        else if (kill_cnt_q != '0)         top_ev_c = EV_KILL;
        else if (shot_pend_q)              top_ev_c = EV_SHOT;
    end

    assign pop_shot  = pop && (top_ev_c == EV_SHOT);
    assign pop_kill  = pop && (top_ev_c == EV_KILL);
    assign pop_death = pop && (top_ev_c == EV_DEATH);

    // New requests win over a same-cycle pop; kill count saturates at 7.
    always_comb begin
        shot_pend_d  = shot_pend_q;
        death_pend_d = death_pend_q;
        kill_cnt_d   = kill_cnt_q;
        kill_sum     = (KCNT_W+1)'(kill_cnt_q) + (KCNT_W+1)'(req.kills)
                     - (KCNT_W+1)'(pop_kill);
        if (!freeze) begin
            shot_pend_d  = req.shot  | (shot_pend_q  & ~pop_shot);
            death_pend_d = req.death | (death_pend_q & ~pop_death);
            kill_cnt_d   = (kill_sum > (KCNT_W+1)'(7)) ? KCNT_W'(7) : kill_sum[KCNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shot_pend_q  <= 1'b0;
            death_pend_q <= 1'b0;
            kill_cnt_q   <= '0;
        end else begin
            shot_pend_q  <= shot_pend_d;
            death_pend_q <= death_pend_d;
            kill_cnt_q   <= kill_cnt_d;
        end
    end

endmodule

// File: rtl/sound_event_scheduler.sv
// Schedules shot/kill/death sounds onto one tone channel for fixed tick counts.
// Define SOUND_GAP_EN to insert one silent slowClk tick after each non-death sound.
module sound_event_scheduler
    import sound_pkg::*;
#(
    parameter int unsigned SHOT_TICKS  = 2,
    parameter int unsigned KILL_TICKS  = 3,
    parameter int unsigned DEATH_TICKS = 5
) (
    input logic                    clk,
    input logic                    reset,
    sound_event_scheduler_if.slave bus
);

    sched_state_t      state_q, state_d;
    event_t            cur_ev_q, cur_ev_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [KEY_W-1:0]  sound_key_q, sound_key_d;
    logic              sound_active_q, sound_active_d;
    logic              game_over_q, game_over_d;
    logic              pop;
    event_t            top_ev_c;
    ev_req_t           req;

    function automatic logic [TICK_W-1:0] ev_ticks(input event_t ev);
        logic [TICK_W-1:0] t;
        t = TICK_W'(SHOT_TICKS);
        if (ev == EV_KILL)       t = TICK_W'(KILL_TICKS);
        else if (ev == EV_DEATH) t = TICK_W'(DEATH_TICKS);
        return t;
    endfunction

    assign req = '{bus.shotFired, bus.enemyDead, bus.playerDead};

    sound_pending_queue u_queue (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .freeze   (state_q == S_END),
        .pop      (pop),
        .top_ev_c (top_ev_c)
    );

    // Next state; a tick in the cycle a sound starts is never counted.
    always_comb begin
        state_d    = state_q;
        cur_ev_d   = cur_ev_q;
        tick_cnt_d = tick_cnt_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (top_ev_c != EV_NONE) begin
                    state_d    = S_PLAY;
                    cur_ev_d   = top_ev_c;
                    tick_cnt_d = ev_ticks(top_ev_c);
                    pop        = 1'b1;
                end
            end
            S_PLAY: begin
                if (cur_ev_q != EV_DEATH && top_ev_c == EV_DEATH) begin
                    cur_ev_d   = EV_DEATH;
                    tick_cnt_d = ev_ticks(EV_DEATH);
                    pop        = 1'b1;
                end else if (bus.slowClk) begin
                    tick_cnt_d = tick_cnt_q - TICK_W'(1);
                    if (tick_cnt_q == TICK_W'(1)) begin
                        cur_ev_d = EV_NONE;
`ifdef SOUND_GAP_EN
                        state_d  = (cur_ev_q == EV_DEATH) ? S_END : S_GAP;
`else
                        state_d  = (cur_ev_q == EV_DEATH) ? S_END : S_IDLE;
`endif
                    end
                end
            end
`ifdef SOUND_GAP_EN
            S_GAP: begin
                if (top_ev_c == EV_DEATH) begin
                    state_d    = S_PLAY;
                    cur_ev_d   = EV_DEATH;
                    tick_cnt_d = ev_ticks(EV_DEATH);
                    pop        = 1'b1;
                end else if (bus.slowClk) begin
                    state_d = S_IDLE;
                end
            end
`endif
            S_END: begin
                state_d = S_END;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sound_key_d    = (state_d == S_PLAY) ? event_key(cur_ev_d) : KEY_SILENT;
        sound_active_d = (state_d == S_PLAY);
        game_over_d    = (state_d == S_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cur_ev_q       <= EV_NONE;
            tick_cnt_q     <= '0;
            sound_key_q    <= KEY_SILENT;
            sound_active_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_ev_q       <= cur_ev_d;
            tick_cnt_q     <= tick_cnt_d;
            sound_key_q    <= sound_key_d;
            sound_active_q <= sound_active_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.sound_key    = sound_key_q;
    assign bus.sound_active = sound_active_q;
    assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Testbench for sound_event_scheduler: directed table, hand-written corner
// sequences and random traffic, all compared against an event-level model.
module tb_sound_event_scheduler;

    localparam int SHOT_T  = 2;
    localparam int KILL_T  = 3;
    localparam int DEATH_T = 5;
`ifdef SOUND_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sound_event_scheduler_if bus();

    sound_event_scheduler #(
        .SHOT_TICKS (SHOT_T),
        .KILL_TICKS (KILL_T),
        .DEATH_TICKS(DEATH_T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: sound being played (by its key code, 0 = none),
    // ticks left, pending requests, gap and game-over flags.
    int m_cur = 0, m_left = 0, m_kills = 0;
    bit m_shot = 0, m_death = 0, m_over = 0, m_gap = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit sh, input int ed, input bit pd, input bit sc, input bit rs);
        bit took_shot = 0, took_kill = 0, took_death = 0;
        if (rs) begin
            m_cur = 0; m_left = 0; m_kills = 0;
            m_shot = 0; m_death = 0; m_over = 0; m_gap = 0;
            return;
        end
        if (m_over) return;
        if (m_death && m_cur != 2) begin
            m_cur = 2; m_left = DEATH_T; m_gap = 0; took_death = 1;
        end else if (m_cur == 0 && !m_gap) begin
            if (m_kills > 0) begin
                m_cur = 3; m_left = KILL_T; took_kill = 1;
            end else if (m_shot) begin
                m_cur = 1; m_left = SHOT_T; took_shot = 1;
            end
        end else if (sc) begin
            if (m_gap) m_gap = 0;
            else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_cur == 2) m_over = 1;
                    else m_gap = GAP;
                    m_cur = 0;
                end
            end
        end
        m_shot  = sh | (m_shot & !took_shot);
        m_death = pd | (m_death & !took_death);
        m_kills = m_kills + ed - int'(took_kill);
        if (m_kills > 7) m_kills = 7;
    endtask

    // One clock: drive inputs, advance model, compare all outputs.
    task automatic step(input logic sh, input logic [2:0] ed, input logic pd,
                        input logic sc, input logic rs);
        reset          = rs;
        bus.shotFired  = sh;
        bus.enemyDead  = ed;
        bus.playerDead = pd;
        bus.slowClk    = sc;
        @(posedge clk);
        model_step(sh, int'(ed), pd, sc, rs);
        cyc++;
        @(negedge clk);
        chk("model_key",    int'(bus.sound_key),    (m_cur == 0) ? 15 : m_cur);
        chk("model_active", int'(bus.sound_active), int'(m_cur != 0));
        chk("model_over",   int'(bus.game_over),    int'(m_over));
    endtask

    function automatic logic tk();
        return (cyc % 4) == 3;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, tk(), 1'b0);
    endtask

    task automatic wait_key(input int k, input int budget, input string name);
        int n = 0;
        while (int'(bus.sound_key) != k && n < budget) begin
            idle(1);
            n++;
        end
        chk(name, int'(bus.sound_key), k);
    endtask

    task automatic count_starts(input int k, input int n, output int starts);
        int prev;
        prev   = int'(bus.sound_key);
        starts = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            if (int'(bus.sound_key) == k && prev != k) starts++;
            prev = int'(bus.sound_key);
        end
    endtask

    typedef struct {
        logic       sh;
        logic [2:0] ed;
        logic       pd;
        logic       sc;
        int         key;
        int         act;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int   starts, phase, first_key, second_key, silent, noisy, n;
        logic r_sh, r_pd, r_sc, r_rs;
        logic [2:0] r_ed;

        // Single shot, tick every 4th cycle: key 1 from +2 cycles for 2 ticks.
        for (int i = 0; i < 12; i++)
            tbl[i] = '{(i == 0), 3'd0, 1'b0, (i % 4 == 3),
                       (i >= 1 && i <= 6) ? 1 : 15, (i >= 1 && i <= 6) ? 1 : 0};

        reset = 1'b1; bus.shotFired = 1'b0; bus.enemyDead = 3'd0;
        bus.playerDead = 1'b0; bus.slowClk = 1'b0;
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_key",    int'(bus.sound_key),    15);
        chk("reset_active", int'(bus.sound_active), 0);
        chk("reset_over",   int'(bus.game_over),    0);
        idle(3);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].sh, tbl[i].ed, tbl[i].pd, tbl[i].sc, 1'b0);
            chk("tbl_key", int'(bus.sound_key),    tbl[i].key);
            chk("tbl_act", int'(bus.sound_active), tbl[i].act);
        end
        idle(8);

        // Three kills in one cycle: three separate key-3 sounds.
        step(1'b0, 3'd3, 1'b0, tk(), 1'b0);
        count_starts(3, 80, starts);
        chk("kill3_count", starts, 3);
        chk("kill3_silent", int'(bus.sound_key), 15);

        // Two bursts of 7 while a shot plays: count saturates, 7 kills follow.
        step(1'b1, 3'd0, 1'b0, tk(), 1'b0);
        wait_key(1, 10, "shot_before_burst");
        step(1'b0, 3'd7, 1'b0, tk(), 1'b0);
        step(1'b0, 3'd7, 1'b0, tk(), 1'b0);
        count_starts(3, 220, starts);
        chk("kill7_count", starts, 7);
        chk("kill7_silent", int'(bus.sound_key), 15);

        // Shot and kill together: kill first, then shot after the silence.
        step(1'b1, 3'd1, 1'b0, tk(), 1'b0);
        phase = 0; first_key = 0; second_key = 0; silent = 0;
        for (int i = 0; i < 80 && phase < 3; i++) begin
            idle(1);
            case (phase)
                0: if (bus.sound_key != 4'd15) begin first_key = int'(bus.sound_key); phase = 1; end
                1: if (bus.sound_key == 4'd15) begin silent = 1; phase = 2; end
                2: if (bus.sound_key != 4'd15) begin second_key = int'(bus.sound_key); phase = 3; end
                   else silent++;
                default: ;
            endcase
        end
        chk("pair_first",  first_key,  3);
        chk("pair_second", second_key, 1);
        chk("pair_silent", silent, GAP ? 5 : 1);
        idle(20);

        // Death midway through a kill: key 2 two cycles later, then game over.
        step(1'b0, 3'd1, 1'b0, tk(), 1'b0);
        wait_key(3, 10, "kill_before_death");
        idle(4);
        step(1'b0, 3'd0, 1'b1, tk(), 1'b0);
        chk("death_n1", int'(bus.sound_key), 3);
        idle(1);
        chk("death_n2", int'(bus.sound_key), 2);
        n = 0;
        while (!bus.game_over && n < 100) begin idle(1); n++; end
        chk("game_over",     int'(bus.game_over), 1);
        chk("game_over_key", int'(bus.sound_key), 15);
        noisy = 0;
        for (int i = 0; i < 30; i++) begin
            step(i[0], 3'd7, 1'b0, tk(), 1'b0);
            if (bus.sound_key != 4'd15 || bus.sound_active) noisy++;
        end
        chk("muted_after_over", noisy, 0);
        chk("over_sticky", int'(bus.game_over), 1);

        // Reset during the death sound, then a normal shot.
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 3'd0, 1'b1, tk(), 1'b0);
        wait_key(2, 10, "death_before_reset");
        idle(3);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("midreset_key",  int'(bus.sound_key), 15);
        chk("midreset_over", int'(bus.game_over), 0);
        step(1'b1, 3'd0, 1'b0, tk(), 1'b0);
        wait_key(1, 10, "shot_after_reset");
        idle(20);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            r_sh = ($urandom_range(0, 11) == 0);
            r_ed = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            r_pd = ($urandom_range(0, 249) == 0);
            r_sc = ($urandom_range(0, 2) == 0);
            r_rs = (bus.game_over && $urandom_range(0, 15) == 0) || ($urandom_range(0, 799) == 0);
            step(r_sh, r_ed, r_pd, r_sc, r_rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
